// File: rtl/swrite_sink_engine.sv
// swrite_sink_engine: target-side SRIO request sink. SWRITE payloads are buffered
// and written to memory over AXI in bursts; DOORBELLs latch their info field,
// return a DONE response on tresp and raise a one-cycle irq.
// Ports: aclk/areset (async, active-high); s_axis_treq_* request stream in;
// m_axis_tresp_* response stream out; m_axi_aw*/w*/b* AXI write master;
// swrite_done/db_irq pulses; db_info last doorbell info; err_cnt saturating errors.
// Latency: AW asserted the cycle after payload tlast; IDLE the cycle after B.
// Backpressure: one packet in flight; treq_tready is low while AW/W/B/RESP are busy.
module swrite_sink_engine #(
  parameter int MAX_BURST = 16,  // AXI beats per AW burst (power of 2, <= 32)
  parameter int PKT_BEATS = 32   // payload buffer depth in 64-bit beats
) (
  input  logic        aclk,
  input  logic        areset,
  // SRIO target request stream
  input  logic        s_axis_treq_tvalid,
  output logic        s_axis_treq_tready,
  input  logic [63:0] s_axis_treq_tdata,
  input  logic [7:0]  s_axis_treq_tkeep,
  input  logic        s_axis_treq_tlast,
  // SRIO target response stream
  output logic        m_axis_tresp_tvalid,
  input  logic        m_axis_tresp_tready,
  output logic [63:0] m_axis_tresp_tdata,
  output logic        m_axis_tresp_tlast,
  // AXI write master
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // status
  output logic        swrite_done,
  output logic        db_irq,
  output logic [15:0] db_info,
  output logic [7:0]  err_cnt
);

  localparam int CW  = $clog2(PKT_BEATS + 1);                     // beat counter width
  localparam int IW  = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;   // buffer index width
  localparam logic [7:0] FT_SWRITE   = 8'h60;
  localparam logic [7:0] FT_DOORBELL = 8'hA0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_AW,
    S_W,
    S_B,
    S_RESP,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // latched header
  logic [7:0]  r_tid;
  logic [1:0]  r_prio;
  logic        r_crf;
  logic [31:0] r_addr;
  logic [15:0] r_info;

  // payload bookkeeping
  logic [CW-1:0] r_beat_cnt;   // beats stored in the buffer
  logic [CW-1:0] r_rd_ptr;     // beats already sent on W
  logic [7:0]    r_burst_cnt;  // beat index inside current burst
  logic [7:0]    r_burst_len;  // awlen of current burst
  logic [71:0]   r_buf [PKT_BEATS];

  logic        r_done;
  logic        r_irq;
  logic [15:0] r_db_info;
  logic [7:0]  r_err_cnt;

  // control decode
  logic          w_treq_hs;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic [7:0]    w_ftype;
  logic          w_hdr_ld;
  logic          w_buf_wr;
  logic          w_err_inc;
  logic          w_done_set;
  logic          w_irq_set;
  logic [CW-1:0] w_remain;
  logic [7:0]    w_awlen;
  logic [1:0]    w_prio_rsp;
  logic [71:0]   w_rd_entry;
  logic          w_unused;

  // SRIO payload is big-endian on the wire; AXI memory is little-endian.
  function automatic logic [63:0] f_bswap(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] f_brev(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = k[7-i];
    end
    return r;
  endfunction

  assign w_ftype   = s_axis_treq_tdata[55:48];
  assign w_treq_hs = s_axis_treq_tvalid && s_axis_treq_tready;
  assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_w_hs    = m_axi_wvalid && m_axi_wready;

  // Burst sizing: whatever is left in the buffer, capped at MAX_BURST.
  assign w_remain = r_beat_cnt - r_rd_ptr;
  assign w_awlen  = (w_remain > CW'(MAX_BURST)) ? 8'(MAX_BURST - 1)
                                                : (8'(w_remain) - 8'd1);

  // Response priority is one above the request, saturating at 3.
  assign w_prio_rsp = (r_prio == 2'd3) ? 2'd3 : (r_prio + 2'd1);

  assign w_rd_entry = r_buf[r_rd_ptr[IW-1:0]];

  // Header bits not carried into any decision.
  assign w_unused = ^{s_axis_treq_tdata[47], s_axis_treq_tdata[43:32], r_addr[2:0]};

  // ---------------------------------------------------------------------------
  // FSM next-state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_ld    = 1'b0;
    w_buf_wr    = 1'b0;
    w_err_inc   = 1'b0;
    w_done_set  = 1'b0;
    w_irq_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_treq_hs) begin
          w_hdr_ld = 1'b1;
          if (w_ftype == FT_SWRITE) begin
            // a header-only SWRITE carries nothing to write
            w_state_nxt = s_axis_treq_tlast ? S_IDLE : S_RECV;
          end else if (w_ftype == FT_DOORBELL) begin
            w_state_nxt = s_axis_treq_tlast ? S_RESP : S_DROP;
          end else begin
            w_err_inc   = 1'b1;
            // header-only bad packet is already fully consumed
            w_state_nxt = s_axis_treq_tlast ? S_IDLE : S_DROP;
          end
        end
      end
      S_RECV: begin
        if (w_treq_hs) begin
          if (r_beat_cnt == CW'(PKT_BEATS)) begin
            // buffer full and more payload arriving: discard the packet
            w_err_inc   = 1'b1;
            w_state_nxt = s_axis_treq_tlast ? S_IDLE : S_DROP;
          end else begin
            w_buf_wr = 1'b1;
            if (s_axis_treq_tlast) begin
              w_state_nxt = S_AW;
            end
          end
        end
      end
      S_AW: begin
        if (w_aw_hs) begin
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        if (w_w_hs && m_axi_wlast) begin
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          w_err_inc = (m_axi_bresp != 2'b00);
          if (r_rd_ptr == r_beat_cnt) begin
            w_done_set  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_AW;
          end
        end
      end
      S_RESP: begin
        if (m_axis_tresp_tready) begin
          w_irq_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_treq_hs && s_axis_treq_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tid       <= '0;
      r_prio      <= '0;
      r_crf       <= 1'b0;
      r_addr      <= '0;
      r_info      <= '0;
      r_beat_cnt  <= '0;
      r_rd_ptr    <= '0;
      r_burst_cnt <= '0;
      r_burst_len <= '0;
    end else begin
      if (w_hdr_ld) begin
        r_tid      <= s_axis_treq_tdata[63:56];
        r_prio     <= s_axis_treq_tdata[46:45];
        r_crf      <= s_axis_treq_tdata[44];
        r_addr     <= s_axis_treq_tdata[31:0];
        r_info     <= s_axis_treq_tdata[31:16];
        r_beat_cnt <= '0;
        r_rd_ptr   <= '0;
      end else if (w_buf_wr) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_aw_hs) begin
        r_burst_cnt <= '0;
        r_burst_len <= w_awlen;
      end else if (w_w_hs) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
      if (w_w_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Payload buffer: storage only, validity is tracked by r_beat_cnt.
  always_ff @(posedge aclk) begin
    if (w_buf_wr) begin
      r_buf[r_beat_cnt[IW-1:0]] <= {f_bswap(s_axis_treq_tdata), f_brev(s_axis_treq_tkeep)};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
      r_db_info <= '0;
      r_err_cnt <= '0;
    end else begin
      r_done <= w_done_set;
      r_irq  <= w_irq_set;
      if (w_irq_set) begin
        r_db_info <= r_info;
      end
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // tready is also gated by areset so it reads 0 while reset is held.
  assign s_axis_treq_tready = !areset &&
                              ((r_state == S_IDLE) || (r_state == S_RECV) || (r_state == S_DROP));

  assign m_axis_tresp_tvalid = (r_state == S_RESP);
  assign m_axis_tresp_tlast  = (r_state == S_RESP);
  assign m_axis_tresp_tdata  = {r_tid, 8'hD0, 1'b0, w_prio_rsp, r_crf, 44'd0};

  assign m_axi_awvalid = (r_state == S_AW);
  assign m_axi_awaddr  = {r_addr[31:3], 3'b000} + 32'({r_rd_ptr, 3'b000});
  assign m_axi_awlen   = w_awlen;

  assign m_axi_wvalid = (r_state == S_W);
  assign m_axi_wdata  = w_rd_entry[71:8];
  assign m_axi_wstrb  = w_rd_entry[7:0];
  assign m_axi_wlast  = (r_burst_cnt == r_burst_len);

  assign m_axi_bready = (r_state == S_B);

  assign swrite_done = r_done;
  assign db_irq      = r_irq;
  assign db_info     = r_db_info;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_swrite_sink_engine.sv
// Directed bench for swrite_sink_engine: SWRITE bursts, short SWRITE strobes,
// doorbell responses, bad type, bresp error, overflow and reset mid-W.
module tb_swrite_sink_engine;

  logic        aclk;
  logic        areset;
  logic        s_axis_treq_tvalid;
  logic        s_axis_treq_tready;
  logic [63:0] s_axis_treq_tdata;
  logic [7:0]  s_axis_treq_tkeep;
  logic        s_axis_treq_tlast;
  logic        m_axis_tresp_tvalid;
  logic        m_axis_tresp_tready;
  logic [63:0] m_axis_tresp_tdata;
  logic        m_axis_tresp_tlast;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        swrite_done;
  logic        db_irq;
  logic [15:0] db_info;
  logic [7:0]  err_cnt;

  swrite_sink_engine #(.MAX_BURST(16), .PKT_BEATS(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_treq_tvalid(s_axis_treq_tvalid), .s_axis_treq_tready(s_axis_treq_tready),
    .s_axis_treq_tdata(s_axis_treq_tdata), .s_axis_treq_tkeep(s_axis_treq_tkeep),
    .s_axis_treq_tlast(s_axis_treq_tlast),
    .m_axis_tresp_tvalid(m_axis_tresp_tvalid), .m_axis_tresp_tready(m_axis_tresp_tready),
    .m_axis_tresp_tdata(m_axis_tresp_tdata), .m_axis_tresp_tlast(m_axis_tresp_tlast),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .swrite_done(swrite_done), .db_irq(db_irq), .db_info(db_info), .err_cnt(err_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // capture of everything the DUT emits
  logic [39:0] aw_q[$];
  logic [63:0] w_dat_q[$];
  logic [7:0]  w_stb_q[$];
  logic        w_lst_q[$];
  logic [63:0] rsp_q[$];
  logic        rsp_lst_q[$];
  int          n_done = 0;
  int          n_irq  = 0;
  int          b_pend = 0;
  bit          gap    = 0;
  bit          bad_b  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] d);
    return {<<8{d}};
  endfunction

  function automatic logic [63:0] pat(input logic [31:0] seed, input int i);
    return {seed ^ 32'(i), ~32'(i)};
  endfunction

  // AXI slave / tresp sink / pulse monitor. Everything is decided on the
  // falling edge; a handshake seen here completes at the next rising edge.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axis_tresp_tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_axi_bvalid = 1'b0;
      end else begin
        bit b_add;
        b_add = 1'b0;
        m_axi_awready       = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready        = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axis_tresp_tready = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_bvalid        = (b_pend > 0);
        m_axi_bresp         = (m_axi_bvalid && bad_b) ? 2'b10 : 2'b00;
        if (m_axi_awvalid && m_axi_awready) aw_q.push_back({m_axi_awaddr, m_axi_awlen});
        if (m_axi_wvalid && m_axi_wready) begin
          w_dat_q.push_back(m_axi_wdata);
          w_stb_q.push_back(m_axi_wstrb);
          w_lst_q.push_back(m_axi_wlast);
          b_add = m_axi_wlast;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_pend--;
          bad_b = 1'b0;
        end
        if (b_add) b_pend++;
        if (m_axis_tresp_tvalid && m_axis_tresp_tready) begin
          rsp_q.push_back(m_axis_tresp_tdata);
          rsp_lst_q.push_back(m_axis_tresp_tlast);
        end
        if (swrite_done) n_done++;
        if (db_irq) n_irq++;
      end
    end
  end

  task automatic clear_caps();
    aw_q.delete(); w_dat_q.delete(); w_stb_q.delete(); w_lst_q.delete();
    rsp_q.delete(); rsp_lst_q.delete();
    n_done = 0; n_irq = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    s_axis_treq_tdata  = d;
    s_axis_treq_tkeep  = k;
    s_axis_treq_tlast  = l;
    s_axis_treq_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_axis_treq_tready && t < 500);
    if (!s_axis_treq_tready) chk("treq_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_axis_treq_tvalid = 1'b0;
    s_axis_treq_tlast  = 1'b0;
  endtask

  task automatic send_swrite(input logic [31:0] addr, input int n,
                             input logic [7:0] lastk, input logic [31:0] seed);
    send_beat({8'h11, 8'h60, 16'h0000, addr}, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_beat(pat(seed, i), (i == n - 1) ? lastk : 8'hFF, (i == n - 1));
    end
  endtask

  // Wait (bounded) for the pulse counts, let things settle, then check them.
  task automatic wait_pulses(input string tag, input int want_done, input int want_irq);
    for (int t = 0; t < 3000 && (n_done < want_done || n_irq < want_irq); t++) begin
      @(negedge aclk);
    end
    repeat (4) @(negedge aclk);
    chk({tag, "_done"}, 64'(n_done), 64'(want_done));
    chk({tag, "_irq"}, 64'(n_irq), 64'(want_irq));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [31:0] lmask;
    logic [7:0]  sand;

    areset = 1'b1;
    s_axis_treq_tvalid = 1'b0; s_axis_treq_tdata = '0;
    s_axis_treq_tkeep = '0;    s_axis_treq_tlast = 1'b0;

    // ---- reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ctrl", 64'({s_axis_treq_tready, m_axis_tresp_tvalid, m_axi_awvalid,
                         m_axi_wvalid, m_axi_bready, swrite_done, db_irq}), 64'd0);
    chk("rst_info", 64'(db_info), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_rdy", 64'(s_axis_treq_tready), 64'd1);
    @(posedge aclk); #1;

    // ---- 1: full 256-byte SWRITE, two bursts of 16
    clear_caps(); gap = 0;
    send_swrite(32'h0000_1000, 32, 8'hFF, 32'h0123_4567);
    wait_pulses("t1", 1, 0);
    chk("t1_awcnt", 64'(aw_q.size()), 64'd2);
    chk("t1_aw0", 64'(aw_q[0]), {24'd0, 32'h0000_1000, 8'd15});
    chk("t1_aw1", 64'(aw_q[1]), {24'd0, 32'h0000_1080, 8'd15});
    chk("t1_wcnt", 64'(w_dat_q.size()), 64'd32);
    chk("t1_w0", w_dat_q[0], 64'hFFFF_FFFF_6745_2301);
    lmask = '0; sand = 8'hFF;
    for (int i = 0; i < w_dat_q.size(); i++) begin
      chk("t1_wdat", w_dat_q[i], bswap(pat(32'h0123_4567, i)));
      lmask[i] = w_lst_q[i];
      sand &= w_stb_q[i];
    end
    chk("t1_wlast", 64'(lmask), 64'h8000_8000);
    chk("t1_wstrb", 64'(sand), 64'hFF);
    chk("t1_err", 64'(err_cnt), 64'd0);

    // ---- 2: 5-beat SWRITE with partial last beat, random backpressure
    clear_caps(); gap = 1;
    send_swrite(32'h0000_2000, 5, 8'h0F, 32'h1122_3344);
    wait_pulses("t2", 1, 0);
    chk("t2_awcnt", 64'(aw_q.size()), 64'd1);
    chk("t2_aw0", 64'(aw_q[0]), {24'd0, 32'h0000_2000, 8'd4});
    chk("t2_wcnt", 64'(w_dat_q.size()), 64'd5);
    chk("t2_w4", w_dat_q[4], 64'hFBFF_FFFF_4033_2211);
    chk("t2_stb0", 64'(w_stb_q[0]), 64'hFF);
    chk("t2_stb4", 64'(w_stb_q[4]), 64'hF0);
    lmask = '0;
    for (int i = 0; i < w_lst_q.size(); i++) lmask[i] = w_lst_q[i];
    chk("t2_wlast", 64'(lmask), 64'h10);

    // ---- 3: doorbells, prio 1 -> 2 and prio 3 saturating
    clear_caps();
    send_beat(64'h81A0_2000_BEEF_0000, 8'h00, 1'b1);
    wait_pulses("t3a", 0, 1);
    chk("t3a_rcnt", 64'(rsp_q.size()), 64'd1);
    chk("t3a_rsp", rsp_q[0], 64'h81D0_4000_0000_0000);
    chk("t3a_tlast", 64'(rsp_lst_q[0]), 64'd1);
    chk("t3a_info", 64'(db_info), 64'hBEEF);
    chk("t3a_noaw", 64'(aw_q.size()), 64'd0);
    clear_caps();
    send_beat(64'h05A0_7000_1234_0000, 8'h00, 1'b1);
    wait_pulses("t3b", 0, 1);
    chk("t3b_rsp", rsp_q[0], 64'h05D0_7000_0000_0000);
    chk("t3b_info", 64'(db_info), 64'h1234);

    // ---- 4: unsupported type 0x20, three beats, all consumed
    clear_caps(); gap = 0;
    send_beat(64'h0720_0000_0000_3000, 8'h00, 1'b0);
    send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    send_beat(64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b1);
    wait_pulses("t4", 0, 0);
    chk("t4_err", 64'(err_cnt), 64'd1);
    chk("t4_noaw", 64'(aw_q.size()), 64'd0);
    chk("t4_now", 64'(w_dat_q.size()), 64'd0);
    chk("t4_rdy", 64'(s_axis_treq_tready), 64'd1);

    // ---- 5: bresp SLVERR on first burst, second burst still issued
    clear_caps(); gap = 1; bad_b = 1;
    send_swrite(32'h0000_3000, 32, 8'hFF, 32'hA5A5_A5A5);
    wait_pulses("t5", 1, 0);
    chk("t5_awcnt", 64'(aw_q.size()), 64'd2);
    chk("t5_aw1", 64'(aw_q[1]), {24'd0, 32'h0000_3080, 8'd15});
    chk("t5_wcnt", 64'(w_dat_q.size()), 64'd32);
    chk("t5_err", 64'(err_cnt), 64'd2);

    // ---- 6: payload overflow (34 beats) is dropped without AXI traffic
    clear_caps(); gap = 0;
    send_beat({8'h22, 8'h60, 16'h0000, 32'h0000_5000}, 8'h00, 1'b0);
    for (int i = 0; i < 34; i++) send_beat(pat(32'h5555_0000, i), 8'hFF, (i == 33));
    wait_pulses("t6", 0, 0);
    chk("t6_err", 64'(err_cnt), 64'd3);
    chk("t6_noaw", 64'(aw_q.size()), 64'd0);
    chk("t6_rdy", 64'(s_axis_treq_tready), 64'd1);

    // ---- 7: reset in the middle of W, then recovery
    clear_caps(); gap = 0;
    send_swrite(32'h0000_4000, 32, 8'hFF, 32'h7777_0000);
    for (int t = 0; t < 200 && !m_axi_wvalid; t++) @(negedge aclk);
    chk("t7_inW", 64'(m_axi_wvalid), 64'd1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    chk("t7_ctrl", 64'({s_axis_treq_tready, m_axis_tresp_tvalid, m_axi_awvalid,
                        m_axi_wvalid, m_axi_bready, swrite_done, db_irq}), 64'd0);
    chk("t7_info", 64'(db_info), 64'd0);
    chk("t7_err", 64'(err_cnt), 64'd0);
    @(posedge aclk); #1;
    b_pend = 0;
    clear_caps();
    areset = 1'b0;
    @(posedge aclk); #1;
    send_beat(64'h42A0_0000_CAFE_0000, 8'h00, 1'b1);
    wait_pulses("t7", 0, 1);
    chk("t7_rsp", rsp_q[0], 64'h42D0_2000_0000_0000);
    chk("t7_dbinfo", 64'(db_info), 64'hCAFE);
    chk("t7_noaw", 64'(aw_q.size()), 64'd0);
    chk("t7_now", 64'(w_dat_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
